spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target_pkg.sv | 19 +
 rtl/spi_target_if.sv | 30 +++
 rtl/spi_target_sync_edge.sv | 30 +++
 rtl/spi_target.sv | 131 +++++++++++++
 tb/tb_spi_target.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_pkg.sv
// Shared SPI constants and types used by both the initiator and the target.
// The target imports the byte width, clock polarity, idle MISO level and FSM state type.
package spi_target_pkg;

    localparam int         SPI_BYTE_W        = 8;
    localparam logic       SPI_CPOL          = 1'b0;
    localparam logic       SPI_MISO_IDLE     = 1'b0;
    localparam logic [7:0] SPI_UNDERRUN_BYTE = 8'h00;

    // Initiator-side defaults (SCK half period in system clocks, bits per frame)
    localparam int         SPI_INIT_HALF_PERIOD = 6;
    localparam int         SPI_INIT_FRAME_BITS  = SPI_BYTE_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_target_if.sv
// Bundle of the SPI pins and the byte-level transmit/receive interface of spi_target.
interface spi_target_if;
    import spi_target_pkg::*;

    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_cs_n;
    logic                  spi_miso;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_ready;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;

    // Handshakes: tx_load is a one-cycle write into the holding register (accepted
    // whatever tx_ready is; a load while tx_ready is low overwrites the byte);
    // tx_ready is high while the holding register is empty; rx_valid is a
    // one-cycle pulse that marks the cycle rx_data changes; there is no backpressure.
    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, tx_data, tx_load,
        output spi_miso, tx_ready, rx_data, rx_valid, tx_underrun
    );

    modport master (
        output spi_sck, spi_mosi, spi_cs_n, tx_data, tx_load,
        input  spi_miso, tx_ready, rx_data, rx_valid, tx_underrun
    );

endinterface

// File: rtl/spi_target_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall detection
// taken from the last two synchronized samples.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (CPOL=0, MSB first, 8-bit bytes) running entirely in the clk domain:
// SCK/CS_n/MOSI are oversampled and the protocol is driven from detected SCK edges.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_target_if.slave     bus,
    output spi_state_e      state_o
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0] shift_out_q, shift_out_d;
    logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [SPI_BYTE_W-1:0] hold_q, hold_d;
    logic [SPI_BYTE_W-1:0] out_word;
    logic                  hold_full_q, hold_full_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  miso_q, miso_d;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .async_i(bus.spi_sck), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .async_i(bus.spi_cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_out_q <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= SPI_MISO_IDLE;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_out_q <= shift_out_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_out_d = shift_out_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        out_word    = shift_out_q;

        if (bus.tx_load) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        // Idle (including the deselect cycle) keeps the byte state cleared, so
        // entering ACTIVE always starts from bit 0; the holding register survives.
        if (state_q == ST_IDLE || cs_rise) begin
            bit_cnt_d   = '0;
            shift_out_d = '0;
            rx_shift_d  = '0;
            miso_d      = SPI_MISO_IDLE;
        end else begin
            if (sck_rise) begin
                if (bit_cnt_q == 3'd0) begin
                    out_word   = hold_full_q ? hold_q : SPI_UNDERRUN_BYTE;
                    underrun_d = ~hold_full_q;
                    // A coincident tx_load keeps the fresh byte and tx_ready low
                    if (!bus.tx_load) hold_full_d = 1'b0;
                end
                miso_d      = out_word[SPI_BYTE_W-1];
                shift_out_d = {out_word[SPI_BYTE_W-2:0], 1'b0};
            end
            if (sck_fall) begin
                rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_d  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                    rx_valid_d = 1'b1;
                end
            end
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives SPI frames as the initiator and checks
// MISO bytes, received data, pulse counts and reset behaviour.
module tb_spi_target;
    import spi_target_pkg::*;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_target_if bus ();
    spi_state_e   state;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state)
    );

    int errors = 0;
    int checks = 0;
    int rxv_cnt = 0;
    int urun_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rxv_cnt++;
        if (bus.tx_underrun === 1'b1) urun_cnt++;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic select_t();
        bus.spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect_t();
        bus.spi_cs_n = 1'b1;
        tick(HALF);
    endtask

    // Shifts nbits of mo (MSB first) and collects MISO at each SCK fall.
    // ld_at >= 0 pulses tx_load ld_at clocks after the first SCK rise is driven;
    // with two sync stages the target acts on that rise at the third clock (ld_at=2).
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int ld_at,
                            input logic [7:0] ld_val, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = mo[7-i];
            bus.spi_sck  = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                if (i == 0 && k == ld_at) begin
                    bus.tx_data = ld_val;
                    bus.tx_load = 1'b1;
                end
                @(negedge clk);
                bus.tx_load = 1'b0;
            end
            bus.spi_sck = 1'b0;
            mi = {mi[6:0], bus.spi_miso};
            tick(HALF);
        end
    endtask

    logic [7:0] mi;
    int rxv0, ur0;

    initial begin
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.tx_load  = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check1("rst_miso", bus.spi_miso, 1'b0);
        check8("rst_rx_data", bus.rx_data, 8'h00);
        check1("rst_rx_valid", bus.rx_valid, 1'b0);
        check1("rst_underrun", bus.tx_underrun, 1'b0);
        check1("rst_tx_ready", bus.tx_ready, 1'b1);
        check1("rst_state_active", state == ST_ACTIVE, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Single byte: return A5, receive 3C
        rxv0 = rxv_cnt; ur0 = urun_cnt;
        load_tx(8'hA5);
        check1("ready_after_load", bus.tx_ready, 1'b0);
        select_t();
        check1("state_selected", state == ST_ACTIVE, 1'b1);
        spi_xfer(8'h3C, 8, -1, 8'h00, mi);
        check8("b1_miso", mi, 8'hA5);
        check8("b1_rx_data", bus.rx_data, 8'h3C);
        check_n("b1_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check_n("b1_underrun_cnt", urun_cnt - ur0, 0);
        check1("b1_tx_ready", bus.tx_ready, 1'b1);
        deselect_t();
        check1("b1_state_idle", state == ST_ACTIVE, 1'b0);
        check1("b1_miso_idle", bus.spi_miso, 1'b0);

        // Back-to-back bytes, holding register reloaded with 5A mid first byte
        rxv0 = rxv_cnt; ur0 = urun_cnt;
        load_tx(8'h11);
        select_t();
        spi_xfer(8'h12, 8, 4, 8'h5A, mi);
        check8("b2a_miso", mi, 8'h11);
        check8("b2a_rx_data", bus.rx_data, 8'h12);
        check1("b2a_tx_ready", bus.tx_ready, 1'b0);
        spi_xfer(8'h34, 8, -1, 8'h00, mi);
        check8("b2b_miso", mi, 8'h5A);
        check8("b2b_rx_data", bus.rx_data, 8'h34);
        check_n("b2_rx_valid_cnt", rxv_cnt - rxv0, 2);
        check_n("b2_underrun_cnt", urun_cnt - ur0, 0);
        deselect_t();

        // Underrun: nothing loaded
        rxv0 = rxv_cnt; ur0 = urun_cnt;
        select_t();
        spi_xfer(8'h77, 8, -1, 8'h00, mi);
        check8("ur_miso", mi, 8'h00);
        check_n("ur_underrun_cnt", urun_cnt - ur0, 1);
        check8("ur_rx_data", bus.rx_data, 8'h77);
        deselect_t();

        // SCK toggling while deselected is ignored
        rxv0 = rxv_cnt;
        spi_xfer(8'hE1, 8, -1, 8'h00, mi);
        check8("idle_sck_miso", mi, 8'h00);
        check_n("idle_sck_rx_valid_cnt", rxv_cnt - rxv0, 0);
        check8("idle_sck_rx_data", bus.rx_data, 8'h77);

        // Partial byte aborted by deselect, then a full FF byte
        rxv0 = rxv_cnt;
        select_t();
        spi_xfer(8'hFF, 5, -1, 8'h00, mi);
        deselect_t();
        check_n("partial_rx_valid_cnt", rxv_cnt - rxv0, 0);
        check8("partial_rx_data", bus.rx_data, 8'h77);
        check1("partial_miso", bus.spi_miso, 1'b0);
        select_t();
        spi_xfer(8'hFF, 8, -1, 8'h00, mi);
        check8("full_ff_rx_data", bus.rx_data, 8'hFF);
        check_n("full_ff_rx_valid_cnt", rxv_cnt - rxv0, 1);
        deselect_t();

        // Reset mid-byte, then a clean selection receiving 81
        rxv0 = rxv_cnt;
        load_tx(8'h9C);
        select_t();
        spi_xfer(8'h81, 4, -1, 8'h00, mi);
        rst_n = 1'b0;
        tick(2);
        check1("mid_rst_miso", bus.spi_miso, 1'b0);
        check8("mid_rst_rx_data", bus.rx_data, 8'h00);
        check1("mid_rst_rx_valid", bus.rx_valid, 1'b0);
        check1("mid_rst_underrun", bus.tx_underrun, 1'b0);
        check1("mid_rst_tx_ready", bus.tx_ready, 1'b1);
        check1("mid_rst_state_active", state == ST_ACTIVE, 1'b0);
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(HALF);
        select_t();
        spi_xfer(8'h81, 8, -1, 8'h00, mi);
        check8("post_rst_rx_data", bus.rx_data, 8'h81);
        check8("post_rst_miso", mi, 8'h00);
        check_n("post_rst_rx_valid_cnt", rxv_cnt - rxv0, 1);
        deselect_t();

        // tx_load coinciding with the byte-start load
        ur0 = urun_cnt;
        load_tx(8'h66);
        select_t();
        spi_xfer(8'h00, 8, 2, 8'hC3, mi);
        check8("coinc_first_miso", mi, 8'h66);
        check1("coinc_tx_ready", bus.tx_ready, 1'b0);
        spi_xfer(8'h00, 8, -1, 8'h00, mi);
        check8("coinc_second_miso", mi, 8'hC3);
        check_n("coinc_underrun_cnt", urun_cnt - ur0, 0);
        deselect_t();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
